// File: rtl/neuron_array.sv
// NUM_NEURONS parallel MAC neurons over one streamed input vector; results leave one neuron per
// beat through a sigmoid ROM or ReLU. Define NEURON_ARRAY_SAT_EN for saturating accumulation.
module neuron_array #(
    parameter int unsigned NUM_NEURONS = 10,
    parameter int unsigned NUM_INPUTS  = 784,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned FRAC_W      = 8,
    parameter int unsigned ACC_W       = 32,
    localparam int unsigned IDX_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          act_mode,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_W-1:0]      in_data,
    input  logic [NUM_NEURONS*DATA_W-1:0] weight,
    input  logic [NUM_NEURONS*DATA_W-1:0] bias,
    output logic [11:0]                   lut_addr,
    output logic                          lut_rden,
    input  logic [7:0]                    lut_q,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [IDX_W-1:0]              out_index,
    output logic [7:0]                    out_data,
    output logic                          busy,
    output logic                          done,
    output logic                          sat_flag
);
    localparam int unsigned CNT_W = $clog2(NUM_INPUTS);
    localparam int unsigned PF    = 2 * FRAC_W;
    localparam logic signed [ACC_W-1:0] HI_MAX = ACC_W'(15);
    localparam logic signed [ACC_W-1:0] HI_MIN = ACC_W'(-16);

    typedef enum logic [2:0] {StIdle, StAccum, StBias, StLutRd, StLutWait, StOut} state_e;

    // Returns {overflow, sum}; the overflow bit is only ever set in the saturating build.
    function automatic logic [ACC_W:0] add_acc(input logic signed [ACC_W-1:0] a,
                                               input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W-1:0] s;
        s = a + b;
`ifdef NEURON_ARRAY_SAT_EN
        if ((a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1])) begin
            return {1'b1, a[ACC_W-1], {(ACC_W-1){~a[ACC_W-1]}}};
        end else begin
            return {1'b0, s};
        end
`else
        return {1'b0, s};
`endif
    endfunction

    function automatic logic signed [ACC_W-1:0] mul_ext(input logic signed [DATA_W-1:0] x,
                                                        input logic signed [DATA_W-1:0] w);
        logic signed [2*DATA_W-1:0] p;
        p = (2*DATA_W)'(x) * (2*DATA_W)'(w);
        return ACC_W'(p);
    endfunction

    function automatic logic signed [ACC_W-1:0] bias_ext(input logic signed [DATA_W-1:0] b);
        return ACC_W'(b) <<< FRAC_W;
    endfunction

    function automatic logic [11:0] addr_of(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] hi;
        hi = a >>> PF;
        if (hi > HI_MAX) return 12'hFFF;
        if (hi < HI_MIN) return 12'h000;
        return {a[ACC_W-1], a[PF+3 -: 11]} + 12'd2048;
    endfunction

    function automatic logic [7:0] relu_of(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] hi;
        hi = a >>> PF;
        if (a[ACC_W-1] || (a == '0)) return 8'h00;
        if (hi > HI_MAX) return 8'hFF;
        return a[PF+3 -: 8];
    endfunction

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        out_index_q, out_index_d;
    logic [7:0]              out_data_q, out_data_d;
    logic                    mode_q, mode_d;
    logic                    sat_q, sat_d;
    logic                    done_q, done_d;
    logic signed [ACC_W-1:0] acc_q [NUM_NEURONS];
    logic signed [ACC_W-1:0] acc_d [NUM_NEURONS];
    logic [ACC_W:0]          sum [NUM_NEURONS];
    logic signed [ACC_W-1:0] acc_sel;
    logic                    last_beat, last_idx;

    assign acc_sel   = acc_q[idx_q];
    assign last_beat = (cnt_q == CNT_W'(NUM_INPUTS - 1));
    assign last_idx  = (idx_q == IDX_W'(NUM_NEURONS - 1));

    // One shared adder per lane: product during ACCUM, scaled bias during BIAS.
    always_comb begin
        for (int i = 0; i < int'(NUM_NEURONS); i++) begin
            sum[i] = add_acc(acc_q[i], (state_q == StBias) ?
                             bias_ext(bias[i*DATA_W +: DATA_W]) :
                             mul_ext(in_data, weight[i*DATA_W +: DATA_W]));
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        mode_d      = mode_q;
        sat_d       = sat_q;
        done_d      = 1'b0;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        acc_d       = acc_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StAccum;
                    cnt_d   = '0;
                    mode_d  = act_mode;
                    sat_d   = 1'b0;
                    for (int i = 0; i < int'(NUM_NEURONS); i++) acc_d[i] = '0;
                end
            end
            StAccum: begin
                if (in_valid) begin
                    for (int i = 0; i < int'(NUM_NEURONS); i++) begin
                        acc_d[i] = sum[i][ACC_W-1:0];
                        sat_d    = sat_d | sum[i][ACC_W];
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_beat) state_d = StBias;
                end
            end
            StBias: begin
                for (int i = 0; i < int'(NUM_NEURONS); i++) begin
                    acc_d[i] = sum[i][ACC_W-1:0];
                    sat_d    = sat_d | sum[i][ACC_W];
                end
                idx_d   = '0;
                state_d = StLutRd;
            end
            StLutRd: state_d = StLutWait;
            StLutWait: begin
                out_data_d  = mode_q ? relu_of(acc_sel) : lut_q;
                out_index_d = idx_q;
                state_d     = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    if (last_idx) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = StLutRd;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            out_index_q <= '0;
            out_data_q  <= '0;
            mode_q      <= 1'b0;
            sat_q       <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < int'(NUM_NEURONS); i++) acc_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            out_index_q <= out_index_d;
            out_data_q  <= out_data_d;
            mode_q      <= mode_d;
            sat_q       <= sat_d;
            done_q      <= done_d;
            acc_q       <= acc_d;
        end
    end

    // The ROM is addressed in both modes so each neuron takes the same number of cycles.
    assign lut_rden  = (state_q == StLutRd);
    assign lut_addr  = lut_rden ? addr_of(acc_sel) : 12'h000;
    assign in_ready  = (state_q == StAccum);
    assign out_valid = (state_q == StOut);
    assign busy      = (state_q != StIdle);
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign done      = done_q;
    assign sat_flag  = sat_q;
endmodule

// File: tb/tb_neuron_array.sv
// Directed bench for neuron_array (2 neurons x 4 inputs); the behavioural sigmoid ROM returns
// addr[11:4] one cycle after lut_rden, so sigmoid results are predictable from the address.
module tb_neuron_array;
    localparam int unsigned NN = 2;
    localparam int unsigned NI = 4;
    localparam int unsigned DW = 16;

`ifdef NEURON_ARRAY_SAT_EN
    localparam logic [11:0] T4_ADDR = 12'd4095;
    localparam logic [7:0]  T4_SIG  = 8'hFF;
    localparam logic [7:0]  T4_RELU = 8'hFF;
    localparam logic        T4_SAT  = 1'b1;
`else
    localparam logic [11:0] T4_ADDR = 12'd1536;
    localparam logic [7:0]  T4_SIG  = 8'h60;
    localparam logic [7:0]  T4_RELU = 8'h00;
    localparam logic        T4_SAT  = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic                 act_mode = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 out_ready = 1'b0;
    logic signed [DW-1:0] in_data = '0;
    logic [NN*DW-1:0]     weight = '0;
    logic [NN*DW-1:0]     bias = '0;
    logic [7:0]           lut_q = '0;
    logic [11:0]          lut_addr;
    logic                 lut_rden, in_ready, out_valid, busy, done, sat_flag;
    logic [0:0]           out_index;
    logic [7:0]           out_data;

    int          n_checks = 0;
    int          n_pass = 0;
    int          done_cnt = 0;
    logic [11:0] addr_log [$];

    neuron_array #(.NUM_NEURONS(NN), .NUM_INPUTS(NI)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .act_mode  (act_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .weight    (weight),
        .bias      (bias),
        .lut_addr  (lut_addr),
        .lut_rden  (lut_rden),
        .lut_q     (lut_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (lut_rden) lut_q <= lut_addr[11:4];

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (lut_rden) addr_log.push_back(lut_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "/in_ready"},  32'(in_ready),  32'd0);
        check({tag, "/lut_addr"},  32'(lut_addr),  32'd0);
        check({tag, "/lut_rden"},  32'(lut_rden),  32'd0);
        check({tag, "/out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "/out_index"}, 32'(out_index), 32'd0);
        check({tag, "/out_data"},  32'(out_data),  32'd0);
        check({tag, "/busy"},      32'(busy),      32'd0);
        check({tag, "/done"},      32'(done),      32'd0);
        check({tag, "/sat_flag"},  32'(sat_flag),  32'd0);
    endtask

    task automatic run(input string tag, input logic mode,
                       input logic [15:0] w0, input logic [15:0] w1,
                       input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] din,
                       input logic [11:0] ea0, input logic [11:0] ea1,
                       input logic [7:0] ed0, input logic [7:0] ed1,
                       input bit stall, input bit hold);
        int         base, dones, n;
        logic [7:0] ed [2];
        ed[0] = ed0;
        ed[1] = ed1;
        base  = addr_log.size();
        dones = done_cnt;
        act_mode = mode;
        weight   = {w1, w0};
        bias     = {b1, b0};
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        act_mode = ~mode;  // mode must have been latched at start
        check({tag, "/busy"},    32'(busy),     32'd1);
        check({tag, "/sat_clr"}, 32'(sat_flag), 32'd0);
        for (int b = 0; b < int'(NI); b++) begin
            if (stall && b == 2) begin
                in_valid = 1'b0;
                in_data  = 16'h7FFF;
                repeat (3) @(negedge clk);
                check({tag, "/stall_rdy"}, 32'(in_ready), 32'd1);
            end
            in_valid = 1'b1;
            in_data  = din;
            @(negedge clk);
        end
        in_valid = 1'b0;
        // Cycle carrying the last beat is cycle 0; out_valid is expected in cycle 4.
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "/latency"}, 32'(n), 32'd4);
        for (int k = 0; k < int'(NN); k++) begin
            if (k > 0) begin
                n = 1;
                while (!out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                check({tag, "/gap"}, 32'(n), 32'd3);
            end
            check({tag, "/data"},  32'(out_data),  32'(ed[k]));
            check({tag, "/index"}, 32'(out_index), 32'(k));
            if (hold && k == 0) begin
                for (int j = 0; j < 5; j++) begin
                    start = (j == 2);
                    @(negedge clk);
                    start = 1'b0;
                    check({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
                    check({tag, "/hold_data"},  32'(out_data),  32'(ed[k]));
                    check({tag, "/hold_index"}, 32'(out_index), 32'd0);
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check({tag, "/drop"}, 32'(out_valid), 32'd0);
        end
        repeat (2) @(negedge clk);
        check({tag, "/done_once"},  32'(done_cnt - dones), 32'd1);
        check({tag, "/idle"},       32'(busy), 32'd0);
        check({tag, "/lut_reads"},  32'(addr_log.size() - base), 32'd2);
        check({tag, "/addr0"},      32'(addr_log[base]), 32'(ea0));
        check({tag, "/addr1"},      32'(addr_log[base+1]), 32'(ea1));
    endtask

    initial begin
        int dones, reads;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset("init");

        run("t1", 1'b0, 16'h0100, 16'hFF00, 16'h0000, 16'h0000, 16'h0100,
            12'd2560, 12'd1536, 8'hA0, 8'h60, 1'b1, 1'b1);

        // Abort after two of four beats.
        dones    = done_cnt;
        act_mode = 1'b0;
        weight   = {16'hFF00, 16'h0100};
        bias     = '0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h0100;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        reads    = addr_log.size();
        @(negedge clk);
        reset = 1'b0;
        check_reset("abort");
        repeat (8) @(negedge clk);
        check("abort/no_done", 32'(done_cnt - dones), 32'd0);
        check("abort/no_lut",  32'(addr_log.size() - reads), 32'd0);
        check("abort/idle",    32'(busy), 32'd0);

        run("t1_again", 1'b0, 16'h0100, 16'hFF00, 16'h0000, 16'h0000, 16'h0100,
            12'd2560, 12'd1536, 8'hA0, 8'h60, 1'b0, 1'b0);
        run("t2_relu", 1'b1, 16'h0100, 16'hFF00, 16'h0000, 16'h0000, 16'h0100,
            12'd2560, 12'd1536, 8'h40, 8'h00, 1'b0, 1'b0);
        run("bias", 1'b1, 16'h0100, 16'hFF00, 16'h0100, 16'h0080, 16'h0100,
            12'd2688, 12'd1600, 8'h50, 8'h00, 1'b0, 1'b0);
        run("t3_sig", 1'b0, 16'h7F00, 16'h8100, 16'h0000, 16'h0000, 16'h0100,
            12'd4095, 12'd0, 8'hFF, 8'h00, 1'b0, 1'b0);
        run("t3_relu", 1'b1, 16'h7F00, 16'h8100, 16'h0000, 16'h0000, 16'h0100,
            12'd4095, 12'd0, 8'hFF, 8'h00, 1'b0, 1'b0);
        run("t4_sig", 1'b0, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF,
            T4_ADDR, T4_ADDR, T4_SIG, T4_SIG, 1'b0, 1'b0);
        check("t4_sig/sat_flag", 32'(sat_flag), 32'(T4_SAT));
        run("t4_relu", 1'b1, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF,
            T4_ADDR, T4_ADDR, T4_RELU, T4_RELU, 1'b0, 1'b0);
        check("t4_relu/sat_flag", 32'(sat_flag), 32'(T4_SAT));

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
